// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction sequencer with subroutine depth tracking
// and overflow/underflow fault trapping.
module control_sequencer #(
    parameter int INST_W      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int MUL_CYCLES  = 3,
    localparam int DW = $clog2(STACK_DEPTH + 1),
    localparam int CW = $clog2(MUL_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [INST_W-1:0] inst,
    input  logic              eq,
    input  logic              carry,
    output logic [3:0]        state,
    output logic              ir_load,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [DW-1:0]     depth,
    output logic              WrEn,
    output logic              pc_load,
    output logic              pc_inc,
    output logic              acc_load,
    output logic              push,
    output logic              pop,
    output logic              data_mux,
    output logic              reg_mux,
    output logic              e,
    output logic              m,
    output logic [1:0]        jump_mux
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC1, EXEC2, EXEC3, HALT, FAULT} state_t;
    state_t cur, nxt;
    logic [INST_W-1:0] ir;
    logic [CW-1:0] cnt;
    logic [3:0] op;
    logic is_sta, is_jmp, is_stp, is_lda, is_jms, is_bbl, is_jeq, is_jmc, is_mul, is_ldr, is_str;
    logic in_exec, x1, ovf, unf, trap, last, long_op;
    assign op     = ir[INST_W-1 -: 4];
    assign is_sta = op == 4'h0;
    assign is_jmp = op == 4'h1;
    assign is_stp = op == 4'h2;
    assign is_lda = op == 4'h3;
    assign is_jms = op == 4'h4;
    assign is_bbl = op == 4'h5;
    assign is_jeq = op == 4'h6;
    assign is_jmc = op == 4'h7;
    assign is_mul = op == 4'hD;
    assign is_ldr = op == 4'hE;
    assign is_str = op == 4'hF;
    assign long_op = is_lda || is_ldr || is_mul;
    // Stack limits are checked in EXEC1 only; a trapped call/return performs no PC action.
    assign ovf  = is_jms && depth == DW'(STACK_DEPTH);
    assign unf  = is_bbl && depth == '0;
    assign last = cnt == CW'(MUL_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= IDLE;
            ir         <= '0;
            cnt        <= '0;
            depth      <= '0;
            fault_code <= '0;
        end else begin
            cur <= nxt;
            if (ir_load) ir <= inst;
            cnt <= (cur == EXEC3) ? cnt + 1'b1 : '0;
            if (push) depth <= depth + 1'b1;
            else if (pop) depth <= depth - 1'b1;
            if (x1 && ovf) fault_code <= 2'b01;
            else if (x1 && unf) fault_code <= 2'b10;
        end
    end
    always_comb begin
        in_exec  = cur == EXEC1 || cur == EXEC2 || cur == EXEC3;
        x1       = cur == EXEC1;
        trap     = x1 && (ovf || unf);
        state    = {cur == EXEC3, cur == EXEC2, x1, cur == FETCH};
        ir_load  = cur == FETCH;
        halted   = cur == HALT;
        fault    = cur == FAULT;
        e        = in_exec && long_op;
        m        = in_exec && is_mul;
        data_mux = in_exec && is_ldr;
        reg_mux  = in_exec && is_str;
        jump_mux = in_exec ? {is_jmc, is_bbl} : 2'b00;
        WrEn     = x1 && (is_sta || is_str);
        push     = x1 && is_jms && !ovf;
        pop      = x1 && is_bbl && !unf;
        pc_load  = x1 && (is_jmp || push || pop || (is_jeq && !eq) || (is_jmc && carry));
        pc_inc   = x1 && !is_stp && !pc_load && !trap;
        acc_load = (cur == EXEC2 && (is_lda || is_ldr)) || (cur == EXEC3 && last);
        nxt      = cur;
        case (cur)
            IDLE, HALT: nxt = start ? FETCH : cur;
            FETCH:      nxt = EXEC1;
            EXEC1:      nxt = trap ? FAULT : is_stp ? HALT : long_op ? EXEC2 : FETCH;
            EXEC2:      nxt = is_mul ? EXEC3 : FETCH;
            EXEC3:      nxt = last ? FETCH : EXEC3;
            default:    nxt = cur;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench; each queued entry holds the expected outputs for
// one cycle and the inputs to drive right after that cycle is sampled.
module tb_control_sequencer;
    localparam logic [3:0] S_0 = 4'b0000, S_F = 4'b0001, S_1 = 4'b0010, S_2 = 4'b0100, S_3 = 4'b1000;
    localparam logic [10:0] NONE = 11'h000, IRL = 11'h400, WRE = 11'h200, PCL = 11'h100,
                            PCI = 11'h080, ACC = 11'h040, PSH = 11'h020, POP = 11'h010,
                            DMX = 11'h008, RMX = 11'h004, EEN = 11'h002, MEN = 11'h001;
    localparam logic [1:0] HLT = 2'b10, FLT = 2'b01;

    typedef struct packed {
        logic [3:0]  st;
        logic [10:0] strb;
        logic [1:0]  jm;
        logic        halted;
        logic        fault;
        logic [1:0]  fc;
        logic [1:0]  dep;
    } outs_t;
    typedef struct {
        outs_t      exp;
        logic [6:0] drv;
    } item_t;

    logic clk = 1'b0;
    logic rst_n, start, eq, carry;
    logic [3:0] inst;
    logic [3:0] state;
    logic ir_load, halted, fault, WrEn, pc_load, pc_inc, acc_load, push, pop, data_mux, reg_mux, e, m;
    logic [1:0] fault_code, depth, jump_mux;
    outs_t obs;
    item_t sb[$];
    logic [6:0] drv;  // {start, carry, eq, inst}
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    control_sequencer #(.INST_W(4), .STACK_DEPTH(2), .MUL_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inst(inst), .eq(eq), .carry(carry),
        .state(state), .ir_load(ir_load), .halted(halted), .fault(fault),
        .fault_code(fault_code), .depth(depth), .WrEn(WrEn), .pc_load(pc_load),
        .pc_inc(pc_inc), .acc_load(acc_load), .push(push), .pop(pop),
        .data_mux(data_mux), .reg_mux(reg_mux), .e(e), .m(m), .jump_mux(jump_mux)
    );

    assign obs = {state, ir_load, WrEn, pc_load, pc_inc, acc_load, push, pop, data_mux,
                  reg_mux, e, m, jump_mux, halted, fault, fault_code, depth};

    function automatic outs_t mk(input logic [3:0] st, input logic [10:0] strb,
                                 input logic [1:0] jm = 2'b00, input logic [1:0] dep = 2'b00,
                                 input logic [1:0] hf = 2'b00, input logic [1:0] fc = 2'b00);
        mk = '{st, strb, jm, hf[1], hf[0], fc, dep};
    endfunction

    task automatic put(input outs_t x);
        sb.push_back('{x, drv});
    endtask

    task automatic apply;
        {start, carry, eq, inst} = drv;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        item_t it;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== mk(S_0, NONE)) $display("FAIL reset_async: got %h expected %h", obs, mk(S_0, NONE));
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        drv = {1'b0, 2'b00, 4'h3};
        apply;
        repeat (3) put(mk(S_0, NONE));
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            it = sb.pop_front();
            total++;
            if (obs !== it.exp) $display("FAIL reset_idle step %0d: got %h expected %h", i, obs, it.exp);
            else passed++;
            {start, carry, eq, inst} = it.drv;
        end
    endtask

    task automatic test_lda;
        item_t it;
        do_reset;
        drv = {1'b1, 2'b00, 4'h3};
        apply;
        put(mk(S_F, IRL));
        put(mk(S_1, PCI | EEN));
        put(mk(S_2, ACC | EEN));
        put(mk(S_F, IRL));
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            it = sb.pop_front();
            total++;
            if (obs !== it.exp) $display("FAIL lda step %0d: got %h expected %h", i, obs, it.exp);
            else passed++;
            {start, carry, eq, inst} = it.drv;
        end
    endtask

    task automatic test_mul;
        item_t it;
        do_reset;
        drv = {1'b1, 2'b00, 4'hD};
        apply;
        put(mk(S_F, IRL));
        put(mk(S_1, PCI | EEN | MEN));
        put(mk(S_2, EEN | MEN));
        put(mk(S_3, EEN | MEN));
        put(mk(S_3, EEN | MEN));
        put(mk(S_3, ACC | EEN | MEN));
        put(mk(S_F, IRL));
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            it = sb.pop_front();
            total++;
            if (obs !== it.exp) $display("FAIL mul step %0d: got %h expected %h", i, obs, it.exp);
            else passed++;
            {start, carry, eq, inst} = it.drv;
        end
    endtask

    task automatic test_ops;
        item_t it;
        do_reset;
        drv = {1'b1, 2'b00, 4'h0};
        apply;
        put(mk(S_F, IRL));
        put(mk(S_1, WRE | PCI));
        drv = {1'b1, 2'b00, 4'hF};
        put(mk(S_F, IRL));
        put(mk(S_1, WRE | PCI | RMX));
        drv = {1'b1, 2'b00, 4'hE};
        put(mk(S_F, IRL));
        put(mk(S_1, PCI | EEN | DMX));
        put(mk(S_2, ACC | EEN | DMX));
        drv = {1'b1, 2'b00, 4'h1};
        put(mk(S_F, IRL));
        put(mk(S_1, PCL));
        drv = {1'b1, 2'b00, 4'h9};
        put(mk(S_F, IRL));
        put(mk(S_1, PCI));
        put(mk(S_F, IRL));
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            it = sb.pop_front();
            total++;
            if (obs !== it.exp) $display("FAIL ops step %0d: got %h expected %h", i, obs, it.exp);
            else passed++;
            {start, carry, eq, inst} = it.drv;
        end
    endtask

    task automatic test_jumps;
        item_t it;
        do_reset;
        drv = {1'b1, 2'b00, 4'h6};
        apply;
        put(mk(S_F, IRL));
        put(mk(S_1, PCL));
        drv = {1'b1, 2'b01, 4'h6};
        put(mk(S_F, IRL));
        put(mk(S_1, PCI));
        drv = {1'b1, 2'b10, 4'h7};
        put(mk(S_F, IRL));
        put(mk(S_1, PCL, 2'b10));
        drv = {1'b1, 2'b00, 4'h7};
        put(mk(S_F, IRL));
        put(mk(S_1, PCI, 2'b10));
        put(mk(S_F, IRL));
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            it = sb.pop_front();
            total++;
            if (obs !== it.exp) $display("FAIL jumps step %0d: got %h expected %h", i, obs, it.exp);
            else passed++;
            {start, carry, eq, inst} = it.drv;
        end
    endtask

    task automatic test_stack;
        item_t it;
        do_reset;
        drv = {1'b1, 2'b00, 4'h4};
        apply;
        put(mk(S_F, IRL));
        put(mk(S_1, PSH | PCL));
        put(mk(S_F, IRL, 2'b00, 2'd1));
        put(mk(S_1, PSH | PCL, 2'b00, 2'd1));
        put(mk(S_F, IRL, 2'b00, 2'd2));
        put(mk(S_1, NONE, 2'b00, 2'd2));
        repeat (3) put(mk(S_0, NONE, 2'b00, 2'd2, FLT, 2'b01));
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            it = sb.pop_front();
            total++;
            if (obs !== it.exp) $display("FAIL stack step %0d: got %h expected %h", i, obs, it.exp);
            else passed++;
            {start, carry, eq, inst} = it.drv;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== mk(S_0, NONE)) $display("FAIL fault_reset: got %h expected %h", obs, mk(S_0, NONE));
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bbl;
        item_t it;
        do_reset;
        drv = {1'b1, 2'b00, 4'h4};
        apply;
        put(mk(S_F, IRL));
        drv = {1'b1, 2'b00, 4'h5};
        put(mk(S_1, PSH | PCL));
        put(mk(S_F, IRL, 2'b00, 2'd1));
        put(mk(S_1, POP | PCL, 2'b01, 2'd1));
        put(mk(S_F, IRL));
        put(mk(S_1, NONE, 2'b01));
        repeat (2) put(mk(S_0, NONE, 2'b00, 2'd0, FLT, 2'b10));
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            it = sb.pop_front();
            total++;
            if (obs !== it.exp) $display("FAIL bbl step %0d: got %h expected %h", i, obs, it.exp);
            else passed++;
            {start, carry, eq, inst} = it.drv;
        end
    endtask

    task automatic test_halt;
        item_t it;
        do_reset;
        drv = {1'b1, 2'b00, 4'h2};
        apply;
        put(mk(S_F, IRL));
        drv = {1'b0, 2'b00, 4'h2};
        put(mk(S_1, NONE));
        put(mk(S_0, NONE, 2'b00, 2'd0, HLT));
        put(mk(S_0, NONE, 2'b00, 2'd0, HLT));
        drv = {1'b1, 2'b00, 4'h8};
        put(mk(S_0, NONE, 2'b00, 2'd0, HLT));
        put(mk(S_F, IRL));
        put(mk(S_1, PCI));
        put(mk(S_F, IRL));
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            it = sb.pop_front();
            total++;
            if (obs !== it.exp) $display("FAIL halt step %0d: got %h expected %h", i, obs, it.exp);
            else passed++;
            {start, carry, eq, inst} = it.drv;
        end
    endtask

    task automatic test_reset_mid_mul;
        item_t it;
        do_reset;
        drv = {1'b1, 2'b00, 4'h4};
        apply;
        put(mk(S_F, IRL));
        drv = {1'b1, 2'b00, 4'hD};
        put(mk(S_1, PSH | PCL));
        put(mk(S_F, IRL, 2'b00, 2'd1));
        put(mk(S_1, PCI | EEN | MEN, 2'b00, 2'd1));
        put(mk(S_2, EEN | MEN, 2'b00, 2'd1));
        put(mk(S_3, EEN | MEN, 2'b00, 2'd1));
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            it = sb.pop_front();
            total++;
            if (obs !== it.exp) $display("FAIL mid_mul step %0d: got %h expected %h", i, obs, it.exp);
            else passed++;
            {start, carry, eq, inst} = it.drv;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== mk(S_0, NONE)) $display("FAIL mid_mul_reset: got %h expected %h", obs, mk(S_0, NONE));
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        drv = {1'b0, 2'b00, 4'hD};
        apply;
        put(mk(S_0, NONE));
        drv = {1'b1, 2'b00, 4'hD};
        put(mk(S_0, NONE));
        put(mk(S_F, IRL));
        put(mk(S_1, PCI | EEN | MEN));
        put(mk(S_2, EEN | MEN));
        put(mk(S_3, EEN | MEN));
        put(mk(S_3, EEN | MEN));
        put(mk(S_3, ACC | EEN | MEN));
        put(mk(S_F, IRL));
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            it = sb.pop_front();
            total++;
            if (obs !== it.exp) $display("FAIL after_reset step %0d: got %h expected %h", i, obs, it.exp);
            else passed++;
            {start, carry, eq, inst} = it.drv;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        eq    = 1'b0;
        carry = 1'b0;
        inst  = 4'h0;
        test_reset;
        test_lda;
        test_mul;
        test_ops;
        test_jumps;
        test_stack;
        test_bbl;
        test_halt;
        test_reset_mid_mul;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
